// File: rtl/need_event_scheduler_if.sv
// need_event_scheduler_if: request/command bundle between the need
// requesters, the scheduler and the level/display FSM.
interface need_event_scheduler_if;
  logic [3:0] req;
  logic       test_mode;
  logic       tick;
  logic [3:0] grant;
  logic [3:0] inc_pulse;
  logic [3:0] dec_pulse;
  logic [1:0] disp_sel;

  modport master (
    output req, test_mode,
    input  tick, grant, inc_pulse, dec_pulse, disp_sel
  );

  modport slave (
    input  req, test_mode,
    output tick, grant, inc_pulse, dec_pulse, disp_sel
  );
endinterface

// File: rtl/need_event_scheduler.sv
// need_event_scheduler: tick prescaler, round-robin owner of the shared
// level-update path, and per-need decay event scheduling.
module need_event_scheduler #(
  parameter int TICK_DIV    = 7500000,
  parameter int HOLD_TICKS  = 6,
  parameter int SLEEP_TICKS = 12,
  parameter int DECAY_TICKS = 24
) (
  input logic                  clk,
  input logic                  rst_n,
  need_event_scheduler_if.slave bus
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAXL = (SLEEP_TICKS > HOLD_TICKS) ? SLEEP_TICKS : HOLD_TICKS;
  localparam int HW   = $clog2(MAXL + 1);

  typedef enum logic [1:0] {IDLE, HOLD, RELEASE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [HW-1:0] limit;
  logic [4:0]    dcy_q [4];
  logic [4:0]    dcy_d [4];
  logic [3:0]    pend_q, pend_d;
  logic [3:0]    lo_oh;
  logic [1:0]    rr_q, rr_d;
  logic [1:0]    g_q, g_d;
  logic [1:0]    pick, idx;
  logic          found;
  logic [3:0]    grant_q, grant_d;
  logic [3:0]    inc_q, inc_d;
  logic [3:0]    dec_q, dec_d;
  logic [1:0]    disp_q, disp_d;

  // Prescaler; tick is registered so it reads 1 in the count==TICK_DIV-1 cycle.
  always_comb begin
    pre_d = pre_q + PW'(1);
    if (pre_q == PW'(TICK_DIV - 1)) pre_d = '0;
    tick_d = (pre_d == PW'(TICK_DIV - 1));
  end

  // Round-robin search for the first requester at or above rr pointer.
  always_comb begin
    pick  = rr_q;
    idx   = rr_q;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = rr_q + 2'(k);
      if (!found && bus.req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  // Grant FSM: next state, owner, hold counting and increment commands.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    grant_d = grant_q;
    disp_d  = disp_q;
    inc_d   = '0;
    limit   = (g_q == 2'd1) ? HW'(SLEEP_TICKS - 1) : HW'(HOLD_TICKS - 1);
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = HOLD;
          g_d     = pick;
          grant_d = 4'b0001 << pick;
          disp_d  = pick;
          hold_d  = '0;
          if (bus.test_mode) inc_d = 4'b0001 << pick;
        end
      end
      HOLD: begin
        if (!bus.req[g_q]) begin
          state_d = RELEASE;
        end else if (bus.test_mode) begin
          hold_d = '0;
        end else if (tick_q) begin
          if (hold_q == limit) begin
            hold_d = '0;
            inc_d  = 4'b0001 << g_q;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
      end
      RELEASE: begin
        grant_d = '0;
        rr_d    = g_q + 2'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Decay counters, pending set and lowest-first drain of decrements.
  always_comb begin
    pend_d = pend_q;
    dec_d  = '0;
    lo_oh  = pend_q & (~pend_q + 4'd1);
    for (int i = 0; i < 4; i++) dcy_d[i] = dcy_q[i];
    if (!bus.test_mode) begin
      for (int i = 0; i < 4; i++) begin
        if (grant_q[i] || (i == 1 && bus.req[1])) begin
          dcy_d[i] = '0;
        end else if (tick_q) begin
          if (dcy_q[i] == 5'(DECAY_TICKS - 1)) begin
            dcy_d[i]  = '0;
            pend_d[i] = 1'b1;
          end else begin
            dcy_d[i] = dcy_q[i] + 5'd1;
          end
        end
      end
      if ((lo_oh & inc_d) == '0) dec_d = lo_oh;
      pend_d = pend_d & ~lo_oh;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pre_q   <= '0;
      tick_q  <= 1'b0;
      hold_q  <= '0;
      pend_q  <= '0;
      rr_q    <= '0;
      g_q     <= '0;
      grant_q <= '0;
      inc_q   <= '0;
      dec_q   <= '0;
      disp_q  <= '0;
      for (int i = 0; i < 4; i++) dcy_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      grant_q <= grant_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      disp_q  <= disp_d;
      for (int i = 0; i < 4; i++) dcy_q[i] <= dcy_d[i];
    end
  end

  assign bus.tick      = tick_q;
  assign bus.grant     = grant_q;
  assign bus.inc_pulse = inc_q;
  assign bus.dec_pulse = dec_q;
  assign bus.disp_sel  = disp_q;

endmodule

// File: tb/tb_need_event_scheduler.sv
// tb_need_event_scheduler: scoreboard bench for the need scheduler,
// fast-tick instance for arbitration/decay plus a TICK_DIV=4 instance.
module tb_need_event_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   dec_chk = 1'b0;
  bit   gap_chk = 1'b0;
  bit   own = 1'b0;
  int   zrun = 0;
  logic [3:0] prev_g = '0;

  logic [3:0] gq [$];
  logic [3:0] iq [$];
  logic [3:0] dq [$];
  int         dec_t [$];

  need_event_scheduler_if bus ();
  need_event_scheduler_if bus4 ();

  need_event_scheduler #(.TICK_DIV(1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  need_event_scheduler #(.TICK_DIV(4)) u_d4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset(input logic tm);
    rst_n = 1'b0;
    bus.req = '0;
    bus.test_mode = tm;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Scoreboard monitor: pops expected grants/incs/decs as they appear.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_g = '0;
      zrun = 0;
      own = 1'b0;
    end else begin
      cyc++;
      if (bus.grant != prev_g && bus.grant != 4'b0) begin
        if (gq.size() != 0) chk("grant", 32'(bus.grant), 32'(gq.pop_front()));
        else chk("grant_extra", 32'(bus.grant), 32'h0);
        if (gap_chk && own) chk("dead_cycles", 32'(zrun), 32'd1);
        own = 1'b1;
      end
      if (bus.grant == 4'b0) zrun++;
      else zrun = 0;
      prev_g = bus.grant;
      if (bus.inc_pulse != 4'b0) begin
        if (iq.size() != 0) chk("inc", 32'(bus.inc_pulse), 32'(iq.pop_front()));
        else chk("inc_extra", 32'(bus.inc_pulse), 32'h0);
      end
      if (dec_chk && bus.dec_pulse != 4'b0) begin
        dec_t.push_back(cyc);
        if (dq.size() != 0) chk("dec", 32'(bus.dec_pulse), 32'(dq.pop_front()));
        else chk("dec_extra", 32'(bus.dec_pulse), 32'h0);
      end
    end
  end

  initial begin
    bus.req = '0;
    bus.test_mode = 1'b0;
    bus4.req = '0;
    bus4.test_mode = 1'b0;

    // reset state
    #3;
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_inc", 32'(bus.inc_pulse), 32'h0);
    chk("rst_dec", 32'(bus.dec_pulse), 32'h0);
    chk("rst_disp", 32'(bus.disp_sel), 32'h0);
    chk("rst_tick1", 32'(bus.tick), 32'h0);
    chk("rst_tick4", 32'(bus4.tick), 32'h0);

    // TICK_DIV=4 tick pattern
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("tick4", 32'(bus4.tick), 32'((k % 4) == 3));
    end

    // single requester held 20 cycles: 3 increments
    do_reset(1'b0);
    gq.push_back(4'b0001);
    repeat (3) iq.push_back(4'b0001);
    bus.req = 4'b0001;
    repeat (20) @(posedge clk);
    #1 bus.req = 4'b0000;
    @(negedge clk);
    chk("tick1", 32'(bus.tick), 32'h1);
    chk("disp_hold", 32'(bus.disp_sel), 32'h0);
    repeat (8) @(negedge clk);
    chk("tick1_b", 32'(bus.tick), 32'h1);
    chk("hold_inc_left", 32'(iq.size()), 32'h0);
    chk("hold_gnt_left", 32'(gq.size()), 32'h0);
    chk("hold_idle", 32'(bus.grant), 32'h0);

    // round-robin, each dropped after its increment
    do_reset(1'b0);
    for (int n = 0; n < 4; n++) begin
      gq.push_back(4'b0001 << n);
      iq.push_back(4'b0001 << n);
    end
    gap_chk = 1'b1;
    bus.req = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      int t;
      logic [3:0] seen;
      t = 0;
      seen = '0;
      while (seen == 4'b0 && t < 40) begin
        @(negedge clk);
        seen = bus.inc_pulse;
        t++;
      end
      if (seen == 4'b0) chk("rr_timeout", 32'(n), 32'hFFFF);
      @(posedge clk);
      #1 bus.req = bus.req & ~seen;
    end
    repeat (5) @(negedge clk);
    gap_chk = 1'b0;
    chk("rr_gnt_left", 32'(gq.size()), 32'h0);
    chk("rr_inc_left", 32'(iq.size()), 32'h0);
    chk("rr_disp_last", 32'(bus.disp_sel), 32'h3);

    // decay: all four expire together, drained lowest first
    do_reset(1'b0);
    dec_t.delete();
    for (int n = 0; n < 4; n++) dq.push_back(4'b0001 << n);
    dec_chk = 1'b1;
    repeat (35) @(negedge clk);
    chk("dec_left", 32'(dq.size()), 32'h0);
    chk("dec_count", 32'(dec_t.size()), 32'h4);
    if (dec_t.size() == 4) chk("dec_consec", 32'(dec_t[3] - dec_t[0]), 32'h3);

    // test mode: one immediate increment, no decrements
    do_reset(1'b1);
    gq.push_back(4'b0100);
    iq.push_back(4'b0100);
    bus.req = 4'b0100;
    repeat (50) @(negedge clk);
    #1 bus.req = 4'b0000;
    repeat (5) @(negedge clk);
    chk("tm_inc_left", 32'(iq.size()), 32'h0);
    chk("tm_gnt_left", 32'(gq.size()), 32'h0);
    chk("tm_disp", 32'(bus.disp_sel), 32'h2);
    dec_chk = 1'b0;

    // async reset mid-HOLD with hold count at 5
    do_reset(1'b0);
    gq.push_back(4'b0001);
    bus.req = 4'b0001;
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", 32'(bus.grant), 32'h0);
    chk("mid_rst_inc", 32'(bus.inc_pulse), 32'h0);
    chk("mid_rst_disp", 32'(bus.disp_sel), 32'h0);
    bus.req = 4'b0000;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_grant", 32'(bus.grant), 32'h0);
    chk("post_rst_inc_q", 32'(iq.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
